// File: rtl/decode_pkg.sv
// Shared opcode/funct constants and the decoded-control entry type for the decode queue.
// Latency: none, declarations only.
// Backpressure: not applicable.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Narrow decoded controls kept beside each stored instruction.
    // The XLEN-wide fields live in their own arrays because the package cannot be parameterised.
    typedef struct packed {
        logic [4:0] regdest;
        logic       writereg;
        logic       readmem;
        logic       writemem;
    } dec_entry_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational instruction decode: destination register, write/mem controls, extended immediate.
// Latency: zero cycles, purely combinational.
// Backpressure: none, it decodes whatever instruction is presented.
module decode_fields
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] instr,
    output logic [4:0]      regdest,
    output logic            writereg,
    output logic            readmem,
    output logic            writemem,
    output logic [XLEN-1:0] imedext
);

    logic [5:0] op;
    logic [5:0] fn;

    assign op = instr[31:26];
    assign fn = instr[5:0];

    // Opcode-driven field decode; logical immediates are zero-extended, everything else sign-extended.
    always_comb begin
        regdest  = instr[20:16];
        writereg = 1'b0;
        readmem  = (op == OP_LW);
        writemem = (op == OP_SW);
        if (op == OP_RTYPE) begin
            regdest  = instr[15:11];
            // jr and the all-zero nop never write a register
            writereg = (fn != FN_JR) && (instr != '0);
        end else if (op == OP_JAL) begin
            regdest  = 5'd31;
            writereg = 1'b1;
        end else begin
            // 0x08..0x0F is the immediate-ALU group
            writereg = (op[5:3] == 3'b001) || (op == OP_LW);
        end
        if ((op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI)) begin
            imedext = {{(XLEN-16){1'b0}}, instr[15:0]};
        end else begin
            imedext = {{(XLEN-16){instr[15]}}, instr[15:0]};
        end
    end

endmodule

// File: rtl/decode_queue.sv
// Decode queue between fetch and issue; decodes on push, DEPTH-entry FIFO (DECODE_QUEUE_BYPASS_EN adds empty-queue bypass).
// Latency: one cycle from push to head; zero cycles through the bypass when DECODE_QUEUE_BYPASS_EN is defined.
// Backpressure: id_if_ready = count < DEPTH from registered state only; head holds while is_ready is low.
module decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       if_id_valid,
    input  logic [XLEN-1:0]            if_id_instruc,
    input  logic [XLEN-1:0]            if_id_nextpc,
    output logic                       id_if_ready,
    input  logic                       flush,
    input  logic                       is_ready,
    output logic                       id_is_valid,
    output logic [XLEN-1:0]            id_is_instruc,
    output logic [XLEN-1:0]            id_is_nextpc,
    output logic [4:0]                 id_is_regdest,
    output logic                       id_is_writereg,
    output logic                       id_is_readmem,
    output logic                       id_is_writemem,
    output logic [XLEN-1:0]            id_is_imedext,
    output logic [$clog2(DEPTH+1)-1:0] id_is_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    dec_entry_t      ctl_mem   [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] npc_mem   [DEPTH];
    logic [XLEN-1:0] imm_mem   [DEPTH];

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic [4:0]      in_regdest;
    logic            in_writereg;
    logic            in_readmem;
    logic            in_writemem;
    logic [XLEN-1:0] in_imedext;
    dec_entry_t      in_ctl;
    dec_entry_t      head_ctl;

    logic            head_vld;
    logic            byp_vld;
    logic            push_en;
    logic            pop_en;

    decode_fields #(.XLEN(XLEN)) u_decode_fields (
        .instr    (if_id_instruc),
        .regdest  (in_regdest),
        .writereg (in_writereg),
        .readmem  (in_readmem),
        .writemem (in_writemem),
        .imedext  (in_imedext)
    );

    assign in_ctl      = '{regdest: in_regdest, writereg: in_writereg,
                           readmem: in_readmem, writemem: in_writemem};
    assign head_ctl    = ctl_mem[rd_ptr];
    assign head_vld    = (count != '0);
    assign id_if_ready = (count < CW'(DEPTH));
    assign id_is_count = count;

`ifdef DECODE_QUEUE_BYPASS_EN
    // An entry that would be popped the moment it lands skips storage entirely.
    assign byp_vld = (count == '0) && if_id_valid && is_ready && !flush;
`else
    assign byp_vld = 1'b0;
`endif

    assign push_en = if_id_valid && id_if_ready && !byp_vld;
    assign pop_en  = head_vld && is_ready;

    // Occupancy and pointers: reset beats flush, flush beats any push/pop in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage has no reset; stale contents are masked at the outputs while the queue is empty.
    always_ff @(posedge clock) begin
        if (push_en && !flush && !reset) begin
            ctl_mem[wr_ptr]   <= in_ctl;
            instr_mem[wr_ptr] <= if_id_instruc;
            npc_mem[wr_ptr]   <= if_id_nextpc;
            imm_mem[wr_ptr]   <= in_imedext;
        end
    end

    // Head presentation: stored head first, then the bypassed entry, otherwise all zero.
    always_comb begin
        id_is_valid    = 1'b0;
        id_is_instruc  = '0;
        id_is_nextpc   = '0;
        id_is_regdest  = '0;
        id_is_writereg = 1'b0;
        id_is_readmem  = 1'b0;
        id_is_writemem = 1'b0;
        id_is_imedext  = '0;
        if (head_vld) begin
            id_is_valid    = 1'b1;
            id_is_instruc  = instr_mem[rd_ptr];
            id_is_nextpc   = npc_mem[rd_ptr];
            id_is_regdest  = head_ctl.regdest;
            id_is_writereg = head_ctl.writereg;
            id_is_readmem  = head_ctl.readmem;
            id_is_writemem = head_ctl.writemem;
            id_is_imedext  = imm_mem[rd_ptr];
        end else if (byp_vld) begin
            id_is_valid    = 1'b1;
            id_is_instruc  = if_id_instruc;
            id_is_nextpc   = if_id_nextpc;
            id_is_regdest  = in_regdest;
            id_is_writereg = in_writereg;
            id_is_readmem  = in_readmem;
            id_is_writemem = in_writemem;
            id_is_imedext  = in_imedext;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Randomised bench for decode_queue with a queue-based reference model and directed corner cases.
// Latency: model expects one-cycle push-to-head (zero with DECODE_QUEUE_BYPASS_EN on an empty queue).
// Backpressure: random is_ready stalls and fill-to-full exercise id_if_ready.
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_id_valid;
    logic [31:0] if_id_instruc;
    logic [31:0] if_id_nextpc;
    logic        id_if_ready;
    logic        flush;
    logic        is_ready;
    logic        id_is_valid;
    logic [31:0] id_is_instruc;
    logic [31:0] id_is_nextpc;
    logic [4:0]  id_is_regdest;
    logic        id_is_writereg;
    logic        id_is_readmem;
    logic        id_is_writemem;
    logic [31:0] id_is_imedext;
    logic [2:0]  id_is_count;

    int total = 0;
    int bad   = 0;

    // Reference model contents: {instruction, nextpc} in arrival order.
    logic [63:0] model_q[$];

    decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock          (clock),
        .reset          (reset),
        .if_id_valid    (if_id_valid),
        .if_id_instruc  (if_id_instruc),
        .if_id_nextpc   (if_id_nextpc),
        .id_if_ready    (id_if_ready),
        .flush          (flush),
        .is_ready       (is_ready),
        .id_is_valid    (id_is_valid),
        .id_is_instruc  (id_is_instruc),
        .id_is_nextpc   (id_is_nextpc),
        .id_is_regdest  (id_is_regdest),
        .id_is_writereg (id_is_writereg),
        .id_is_readmem  (id_is_readmem),
        .id_is_writemem (id_is_writemem),
        .id_is_imedext  (id_is_imedext),
        .id_is_count    (id_is_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decode written straight from the instruction-set rules.
    function automatic void ref_dec(input logic [31:0] ins, output logic [4:0] rd,
                                    output logic wr, output logic rm, output logic wm,
                                    output logic [31:0] imm);
        int op;
        int fn;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        if (op == 0) begin
            rd = ins[15:11];
            wr = !(fn == 8 || ins == 32'd0);
        end else if (op == 3) begin
            rd = 5'd31;
            wr = 1'b1;
        end else begin
            rd = ins[20:16];
            wr = (op >= 8 && op <= 15) || op == 'h23;
        end
        rm = (op == 'h23);
        wm = (op == 'h2B);
        if (op >= 'h0C && op <= 'h0E) imm = {16'h0000, ins[15:0]};
        else                          imm = {{16{ins[15]}}, ins[15:0]};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops [12] = '{6'h00, 6'h03, 6'h08, 6'h09, 6'h0C, 6'h0D,
                                  6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02};
        logic [31:0] r;
        r = $urandom;
        r[31:26] = ops[$urandom_range(0, 11)];
        if ($urandom_range(0, 3) == 0)  r[5:0] = 6'h08;
        if ($urandom_range(0, 15) == 0) r = 32'd0;
        return r;
    endfunction

    // One clock: drive inputs, compare outputs to the model mid-cycle, advance the model, cross the edge.
    task automatic step(input logic rst, input logic fl, input logic v,
                        input logic [31:0] ins, input logic [31:0] npc, input logic rdy);
        int          n;
        logic        byp;
        logic        show;
        logic [31:0] ei;
        logic [31:0] en;
        logic [4:0]  erd;
        logic        ewr;
        logic        erm;
        logic        ewm;
        logic [31:0] eimm;
        reset = rst; flush = fl; if_id_valid = v;
        if_id_instruc = ins; if_id_nextpc = npc; is_ready = rdy;
        #4;
        n   = model_q.size();
        byp = 1'b0;
`ifdef DECODE_QUEUE_BYPASS_EN
        byp = (n == 0) && v && rdy && !fl;
`endif
        show = 1'b1;
        if (n != 0)   {ei, en} = model_q[0];
        else if (byp) {ei, en} = {ins, npc};
        else begin
            {ei, en} = 64'd0;
            show = 1'b0;
        end
        ref_dec(ei, erd, ewr, erm, ewm, eimm);
        if (!show) begin
            erd = 5'd0; ewr = 1'b0; erm = 1'b0; ewm = 1'b0; eimm = 32'd0;
        end
        check("valid",    id_is_valid,    (n != 0) || byp);
        check("if_ready", id_if_ready,    n < DEPTH);
        check("count",    id_is_count,    n);
        check("instr",    id_is_instruc,  ei);
        check("nextpc",   id_is_nextpc,   en);
        check("regdest",  id_is_regdest,  erd);
        check("writereg", id_is_writereg, ewr);
        check("readmem",  id_is_readmem,  erm);
        check("writemem", id_is_writemem, ewm);
        check("imedext",  id_is_imedext,  eimm);
        if (rst || fl) begin
            model_q.delete();
        end else begin
            if (n != 0 && rdy)            void'(model_q.pop_front());
            if (v && n < DEPTH && !byp)   model_q.push_back({ins, npc});
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; if_id_valid = 1'b0;
        if_id_instruc = '0; if_id_nextpc = '0; is_ready = 1'b0;
        @(posedge clock);
        #1;

        // reset state
        check("rst_valid", id_is_valid, 1'b0);
        check("rst_ready", id_if_ready, 1'b1);
        check("rst_count", id_is_count, 3'd0);
        step(0, 0, 0, 32'd0, 32'd0, 0);

        // lw decode
        step(0, 0, 1, 32'h8C820004, 32'h00000104, 0);
        check("lw_rd",  id_is_regdest,  5'd2);
        check("lw_wr",  id_is_writereg, 1'b1);
        check("lw_rm",  id_is_readmem,  1'b1);
        check("lw_imm", id_is_imedext,  32'h00000004);
        step(0, 0, 0, 32'd0, 32'd0, 1);

        // zero- versus sign-extension
        step(0, 0, 1, 32'h3442FFFF, 32'h00000200, 0);
        step(0, 0, 1, 32'h2042FFFF, 32'h00000204, 0);
        check("ori_imm", id_is_imedext, 32'h0000FFFF);
        step(0, 0, 0, 32'd0, 32'd0, 1);
        check("addi_imm", id_is_imedext, 32'hFFFFFFFF);
        step(0, 0, 0, 32'd0, 32'd0, 1);

        // fill past full with issue stalled
        step(1, 0, 0, 32'd0, 32'd0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, rand_instr(), 32'h1000 + 4 * i, 0);
        check("full_count", id_is_count, 3'd4);
        check("full_ready", id_if_ready, 1'b0);
        step(0, 0, 0, 32'd0, 32'd0, 1);
        check("pop_ready", id_if_ready, 1'b1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 32'd0, 32'd0, 1);

        // flush with simultaneous push and pop
        for (int i = 0; i < 3; i++) step(0, 0, 1, rand_instr(), 32'h2000 + 4 * i, 0);
        step(0, 1, 1, rand_instr(), 32'h3000, 1);
        check("flush_count", id_is_count, 3'd0);
        check("flush_valid", id_is_valid, 1'b0);
        step(0, 0, 0, 32'd0, 32'd0, 0);

`ifdef DECODE_QUEUE_BYPASS_EN
        // bypass of a nop into an empty queue
        step(0, 0, 1, 32'h00000000, 32'h4000, 1);
        check("byp_count", id_is_count, 3'd0);
        step(0, 0, 0, 32'd0, 32'd0, 0);
`endif

        // random traffic with stalls, wraparound, and occasional flush/reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0), rand_instr(), $urandom,
                 ($urandom_range(0, 2) != 0));
            check("cnt_max", id_is_count <= 3'd4, 1'b1);
        end

        // reset in the middle of a stream
        for (int i = 0; i < 3; i++) step(0, 0, 1, rand_instr(), 32'h5000 + 4 * i, 0);
        step(1, 0, 1, rand_instr(), 32'h6000, 1);
        check("midrst_count", id_is_count, 3'd0);
        check("midrst_ready", id_if_ready, 1'b1);
        step(0, 0, 0, 32'd0, 32'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
